laser_pulse_guard: RTL and testbench

LASER_PULSE_GUARD -- requirements
Module: laser_pulse_guard

---
 rtl/laser_pulse_guard.sv | 166 ++++++++++++++++
 tb/tb_laser_pulse_guard.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/laser_pulse_guard.sv
// Laser pulse safety interlock: synchronizes the pulse pin, checks pulse width,
// repetition rate and a software watchdog, and gates laser power accordingly.
module laser_pulse_guard #(
    parameter int MAX_WIDTH_CYC  = 250000,
    parameter int MIN_PERIOD_CYC = 2500000,
    parameter int WDOG_CYC       = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        laser_pulse,
    input  logic        safety_clear,
    input  logic        wdog_en,
    input  logic        wdog_kick,
    output logic        laser_en,
    output logic [3:0]  status,
    output logic [15:0] pulse_count
);

    localparam int WW = $clog2(MAX_WIDTH_CYC + 2);
    localparam int PW = $clog2(MIN_PERIOD_CYC + 1);
    localparam int DW = $clog2(WDOG_CYC + 1);

    localparam logic [WW-1:0] WIDTH_MAX = WW'(MAX_WIDTH_CYC);
    localparam logic [WW-1:0] WIDTH_SAT = WW'(MAX_WIDTH_CYC + 1);
    localparam logic [PW-1:0] PERIOD_SAT = PW'(MIN_PERIOD_CYC);
    localparam logic [DW-1:0] WDOG_SAT = DW'(WDOG_CYC);
    localparam logic [DW-1:0] WDOG_PRE = DW'(WDOG_CYC - 1);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, p_s_q, p_d_q;
    logic [WW-1:0] width_q, width_d;
    logic [PW-1:0] period_q, period_d;
    logic [DW-1:0] wdog_q, wdog_d;
    logic          seen_q, seen_d;
    logic          pulse_err_q, pulse_err_d;
    logic          rate_err_q, rate_err_d;
    logic          wdog_to_q, wdog_to_d;
    logic [15:0]   count_q, count_d;
    logic          laser_en_q, laser_en_d;

    logic rise;
    logic active;
    logic pulse_set, rate_set, wdog_set, any_set;
    logic clear_ok;

    always_comb begin
        rise      = p_s_q & ~p_d_q;
        active    = (state_q != DISARMED);
        pulse_set = active & p_s_q & ~rise & (width_q == WIDTH_MAX);
        rate_set  = active & rise & seen_q & (period_q < PERIOD_SAT);
        // A kick in the reach cycle restarts the counter, so it wins over the set.
        wdog_set  = active & wdog_en & ~wdog_kick & (wdog_q == WDOG_PRE);
        any_set   = pulse_set | rate_set | wdog_set;
        clear_ok  = safety_clear & ~p_s_q & ~any_set;
    end

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        period_d    = period_q;
        wdog_d      = wdog_q;
        seen_d      = seen_q;
        pulse_err_d = pulse_err_q;
        rate_err_d  = rate_err_q;
        wdog_to_d   = wdog_to_q;
        count_d     = count_q;
        laser_en_d  = (state_q == ARMED);

        if (state_q == DISARMED) begin
            width_d  = '0;
            period_d = '0;
            wdog_d   = '0;
            seen_d   = 1'b0;
            if (safety_clear && !p_s_q) begin
                state_d = ARMED;
            end
        end else begin
            if (rise) begin
                width_d = WW'(1);
            end else if (p_s_q && width_q != WIDTH_SAT) begin
                width_d = width_q + 1'b1;
            end

            if (rise) begin
                period_d = PW'(1);
            end else if (period_q != PERIOD_SAT) begin
                period_d = period_q + 1'b1;
            end

            if (!wdog_en || wdog_kick) begin
                wdog_d = '0;
            end else if (wdog_q != WDOG_SAT) begin
                wdog_d = wdog_q + 1'b1;
            end

            if (rise) begin
                seen_d = 1'b1;
            end

            pulse_err_d = pulse_err_q | pulse_set;
            rate_err_d  = rate_err_q | rate_set;
            wdog_to_d   = wdog_to_q | wdog_set;

            if (state_q == ARMED) begin
                if (rise && !any_set) begin
                    count_d = count_q + 16'd1;
                end
                if (any_set) begin
                    state_d = FAULT;
                end
            end else if (clear_ok) begin
                state_d     = ARMED;
                width_d     = '0;
                period_d    = '0;
                wdog_d      = '0;
                seen_d      = 1'b0;
                pulse_err_d = 1'b0;
                rate_err_d  = 1'b0;
                wdog_to_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DISARMED;
            sync1_q     <= 1'b0;
            p_s_q       <= 1'b0;
            p_d_q       <= 1'b0;
            width_q     <= '0;
            period_q    <= '0;
            wdog_q      <= '0;
            seen_q      <= 1'b0;
            pulse_err_q <= 1'b0;
            rate_err_q  <= 1'b0;
            wdog_to_q   <= 1'b0;
            count_q     <= '0;
            laser_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= laser_pulse;
            p_s_q       <= sync1_q;
            p_d_q       <= p_s_q;
            width_q     <= width_d;
            period_q    <= period_d;
            wdog_q      <= wdog_d;
            seen_q      <= seen_d;
            pulse_err_q <= pulse_err_d;
            rate_err_q  <= rate_err_d;
            wdog_to_q   <= wdog_to_d;
            count_q     <= count_d;
            laser_en_q  <= laser_en_d;
        end
    end

    assign laser_en    = laser_en_q;
    assign status      = {wdog_to_q, rate_err_q, pulse_err_q, (state_q == ARMED)};
    assign pulse_count = count_q;

endmodule

// File: tb/tb_laser_pulse_guard.sv
// Directed bench for laser_pulse_guard with small timing parameters; expectations
// are queued by the stimulus and checked by an independent negedge monitor.
module tb_laser_pulse_guard;

    logic        clk;
    logic        rst;
    logic        laser_pulse;
    logic        safety_clear;
    logic        wdog_en;
    logic        wdog_kick;
    logic        laser_en;
    logic [3:0]  status;
    logic [15:0] pulse_count;

    laser_pulse_guard #(
        .MAX_WIDTH_CYC (10),
        .MIN_PERIOD_CYC(40),
        .WDOG_CYC      (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .laser_pulse (laser_pulse),
        .safety_clear(safety_clear),
        .wdog_en     (wdog_en),
        .wdog_kick   (wdog_kick),
        .laser_en    (laser_en),
        .status      (status),
        .pulse_count (pulse_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        en;
        logic [3:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    // Monitor: each queued expectation is checked against the outputs at the next falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_cmp++;
            if (laser_en !== mon_e.en || status !== mon_e.st || pulse_count !== mon_e.cnt) begin
                n_err++;
                $display("FAIL %s: got en=%b status=%b count=%0d, expected en=%b status=%b count=%0d",
                         mon_e.name, laser_en, status, pulse_count, mon_e.en, mon_e.st, mon_e.cnt);
            end else begin
                $display("ok   %s: en=%b status=%b count=%0d",
                         mon_e.name, laser_en, status, pulse_count);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic en, input logic [3:0] st,
                              input logic [15:0] c);
        exp_t e;
        e.name = nm;
        e.en   = en;
        e.st   = st;
        e.cnt  = c;
        sb_q.push_back(e);
    endtask

    task automatic pulse(input int hi, input int lo);
        laser_pulse = 1'b1;
        step(hi);
        laser_pulse = 1'b0;
        step(lo);
    endtask

    task automatic do_clear();
        safety_clear = 1'b1;
        step(1);
        safety_clear = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        laser_pulse  = 1'b0;
        safety_clear = 1'b0;
        wdog_en      = 1'b0;
        wdog_kick    = 1'b0;
        step(3);
        expect_out("reset", 1'b0, 4'b0000, 16'd0);

        rst = 1'b0;
        step(2);
        do_clear();
        step(2);
        expect_out("armed", 1'b1, 4'b0001, 16'd0);

        // Two legal pulses: width exactly at the limit, spacing exactly at the limit.
        pulse(10, 30);
        pulse(10, 30);
        expect_out("two_pulses", 1'b1, 4'b0001, 16'd2);

        // Over-width pulse: flag on the 11th synced-high cycle, laser_en one cycle later.
        laser_pulse = 1'b1;
        step(11);
        laser_pulse = 1'b0;
        step(1);
        expect_out("pre_pulse_err", 1'b1, 4'b0001, 16'd3);
        step(1);
        expect_out("pulse_err_set", 1'b1, 4'b0010, 16'd3);
        step(1);
        expect_out("pulse_err_en_fall", 1'b0, 4'b0010, 16'd3);
        step(5);
        do_clear();
        step(3);
        expect_out("pulse_err_clear", 1'b1, 4'b0001, 16'd3);

        // Rate violation: rises 39 cycles apart after a fresh reset and arm.
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
        do_clear();
        step(3);
        expect_out("rearm_after_rst", 1'b1, 4'b0001, 16'd0);
        laser_pulse = 1'b1;
        step(10);
        laser_pulse = 1'b0;
        step(29);
        laser_pulse = 1'b1;
        step(2);
        expect_out("pre_rate_err", 1'b1, 4'b0001, 16'd1);
        step(1);
        expect_out("rate_err_set", 1'b1, 4'b0100, 16'd1);
        do_clear();
        step(1);
        expect_out("clear_while_high_ignored", 1'b0, 4'b0100, 16'd1);
        laser_pulse = 1'b0;
        step(5);
        expect_out("clear_not_pending", 1'b0, 4'b0100, 16'd1);
        do_clear();
        step(3);
        expect_out("rate_err_clear", 1'b1, 4'b0001, 16'd1);

        // Watchdog: kicks every 99 cycles, then exactly at the reach cycle, then none.
        wdog_en   = 1'b1;
        wdog_kick = 1'b1;
        step(1);
        wdog_kick = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(98);
            wdog_kick = 1'b1;
            step(1);
            wdog_kick = 1'b0;
        end
        expect_out("wdog_kicked_99", 1'b1, 4'b0001, 16'd1);
        step(99);
        wdog_kick = 1'b1;
        step(1);
        wdog_kick = 1'b0;
        expect_out("wdog_kick_at_reach", 1'b1, 4'b0001, 16'd1);
        step(99);
        expect_out("wdog_pre_timeout", 1'b1, 4'b0001, 16'd1);
        step(1);
        expect_out("wdog_timeout_set", 1'b1, 4'b1000, 16'd1);
        step(1);
        expect_out("wdog_timeout_en_fall", 1'b0, 4'b1000, 16'd1);

        // Reset mid-pulse while in FAULT: back to DISARMED, never self-arms.
        wdog_en     = 1'b0;
        laser_pulse = 1'b1;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        expect_out("rst_mid_pulse", 1'b0, 4'b0000, 16'd0);
        step(5);
        expect_out("no_self_arm", 1'b0, 4'b0000, 16'd0);
        laser_pulse = 1'b0;
        step(5);
        do_clear();
        step(3);
        expect_out("rearm_after_fault_rst", 1'b1, 4'b0001, 16'd0);

        step(3);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
